masked_sbox_sched: RTL

//  Shares one pipelined first-order masked Canright S-box (the shared-factor/inverter datapath) among N_REQ requesters.
//  - Arbitrates requests round-robin.
//  - Pairs each issue with one fresh randomness word from the PRNG.
//  - Tracks in-flight tags and routes each result back to its requester.
//  - Supports quiesce/drain for safe mask reseeding.

---
 rtl/masked_sbox_sched_if.sv | 34 +++
 rtl/masked_sbox_sched.sv | 89 ++++++++
 2 files changed

// File: rtl/masked_sbox_sched_if.sv
// masked_sbox_sched_if: requester, PRNG, shared S-box and response signals of the masked S-box scheduler.
interface masked_sbox_sched_if #(
    parameter int N_REQ = 4,
    parameter int RND_W = 18
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [RND_W-1:0]   rnd_data;
    logic               sb_valid;
    logic [7:0]         sb_a;
    logic [7:0]         sb_b;
    logic [RND_W-1:0]   sb_rnd;
    logic [7:0]         sb_res_a;
    logic [7:0]         sb_res_b;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_a;
    logic [7:0]         rsp_b;
    logic               quiesce;
    logic               idle;

    modport master (
        output req_valid, req_a, req_b, rnd_valid, rnd_data, sb_res_a, sb_res_b, quiesce,
        input  req_ready, rnd_ready, sb_valid, sb_a, sb_b, sb_rnd, rsp_valid, rsp_a, rsp_b, idle
    );

    modport slave (
        input  req_valid, req_a, req_b, rnd_valid, rnd_data, sb_res_a, sb_res_b, quiesce,
        output req_ready, rnd_ready, sb_valid, sb_a, sb_b, sb_rnd, rsp_valid, rsp_a, rsp_b, idle
    );
endinterface

// File: rtl/masked_sbox_sched.sv
// masked_sbox_sched: round-robin sharing of one pipelined masked S-box among N_REQ requesters with quiesce/drain.
// Define SBOX_SCHED_KEYPRIO_EN to give requester 0 (key schedule) absolute priority.
module masked_sbox_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int RND_W = 18
) (
    input logic            clk,
    input logic            rst_n,
    masked_sbox_sched_if.slave io_bus
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_rr_ptr, w_rr_nxt, w_gnt;
    logic [LAT-1:0]   r_tag_v;
    logic [PW-1:0]    r_tag_id [LAT];
    logic [N_REQ-1:0] r_rsp_valid;
    logic [7:0]       r_rsp_a, r_rsp_b;
    logic             w_key, w_issue, w_tag_busy;

`ifdef SBOX_SCHED_KEYPRIO_EN
    assign w_key = io_bus.req_valid[0];
`else
    assign w_key = 1'b0;
`endif

    // Scan downwards from rr_ptr+N-1 so the first valid at or after rr_ptr is the last one written.
    always_comb begin
        logic [PW:0] j;
        j     = '0;
        w_gnt = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = {1'b0, r_rr_ptr} + (PW+1)'(k);
            j = (j >= (PW+1)'(N_REQ)) ? j - (PW+1)'(N_REQ) : j;
            if (io_bus.req_valid[j[PW-1:0]]) w_gnt = j[PW-1:0];
        end
        w_gnt = w_key ? '0 : w_gnt;
    end

    assign w_issue    = rst_n && (r_state == RUN) && (|io_bus.req_valid) && io_bus.rnd_valid && !io_bus.quiesce;
    assign w_tag_busy = |r_tag_v;
    assign w_rr_nxt   = (w_issue && !w_key) ? ((w_gnt == PW'(N_REQ - 1)) ? '0 : w_gnt + 1'b1) : r_rr_ptr;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == RUN)   ? (io_bus.quiesce ? (w_tag_busy ? DRAIN : HALT) : RUN) :
                      (r_state == DRAIN) ? ((w_tag_busy || |r_rsp_valid) ? DRAIN : HALT) :
                                           (io_bus.quiesce ? HALT : RUN);
        io_bus.req_ready = w_issue ? ONE << w_gnt : '0;
        io_bus.rnd_ready = w_issue;
        io_bus.sb_valid  = w_issue;
        io_bus.sb_a      = w_issue ? io_bus.req_a[{w_gnt, 3'b000} +: 8] : '0;
        io_bus.sb_b      = w_issue ? io_bus.req_b[{w_gnt, 3'b000} +: 8] : '0;
        io_bus.sb_rnd    = w_issue ? io_bus.rnd_data : '0;
        io_bus.rsp_valid = r_rsp_valid;
        io_bus.rsp_a     = r_rsp_a;
        io_bus.rsp_b     = r_rsp_b;
        io_bus.idle      = !w_tag_busy && !(|r_rsp_valid) && (r_state != DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_rr_ptr    <= '0;
            r_tag_v     <= '0;
            r_rsp_valid <= '0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_tag_v[0]  <= w_issue;
            for (int i = 1; i < LAT; i++) r_tag_v[i] <= r_tag_v[i-1];
            r_rsp_valid <= r_tag_v[LAT-1] ? ONE << r_tag_id[LAT-1] : '0;
            r_rsp_a     <= r_tag_v[LAT-1] ? io_bus.sb_res_a : '0;
            r_rsp_b     <= r_tag_v[LAT-1] ? io_bus.sb_res_b : '0;
        end
    end

    // Ids are qualified by r_tag_v, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt;
        for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
endmodule
